// File: rtl/if_id_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   ISIZE_DEF    : default instruction-address (PC) width
//   DSIZE_DEF    : default instruction width
//   QDEPTH_DEF   : default decoupling-queue depth
//   RESET_PC_DEF : first fetch address after reset
//   cnt_width()  : bits needed to hold an occupancy of 0..depth
package if_id_stage_pkg;

  localparam int ISIZE_DEF    = 16;
  localparam int DSIZE_DEF    = 16;
  localparam int QDEPTH_DEF   = 2;
  localparam int RESET_PC_DEF = 0;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_id_stage_inst_fifo.sv
// inst_fifo: small synchronous FIFO that holds fetched {instruction, PC+1}.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous clear, wins over push and pop
//   push, din : enqueue din
//   pop       : dequeue head
//   head      : oldest entry (straight from storage, i.e. registered)
//   count     : occupancy 0..DEPTH
//   empty     : count == 0
module inst_fifo
  import if_id_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // a push into a full queue is legal only when the head leaves in the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch PC, instruction-memory request issue, and decoupling
// queue feeding decode under a valid/ready handshake.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   imem_req, imem_addr   : fetch request / word address (combinational)
//   imem_rdata            : instruction, valid the cycle after the request
//   id_ready              : decode accepts the head this cycle
//   redirect, redirect_pc : taken branch and its target; flushes wrong path
//   valid_out, inst_out, npc_out : registered queue head
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int               ISIZE    = ISIZE_DEF,
  parameter int               DSIZE    = DSIZE_DEF,
  parameter int               QDEPTH   = QDEPTH_DEF,
  parameter logic [ISIZE-1:0] RESET_PC = ISIZE'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [ISIZE-1:0] imem_addr,
  input  logic [DSIZE-1:0] imem_rdata,
  input  logic             id_ready,
  input  logic             redirect,
  input  logic [ISIZE-1:0] redirect_pc,
  output logic             valid_out,
  output logic [DSIZE-1:0] inst_out,
  output logic [ISIZE-1:0] npc_out
);

  localparam int CW = cnt_width(QDEPTH);

  logic [ISIZE-1:0] fpc;
  logic             infl;
  logic [ISIZE-1:0] infl_npc;
  logic [ISIZE-1:0] next_pc;
  logic [CW-1:0]    count;
  logic             empty;
  logic             deq;
  logic             enq;
  logic [CW:0]      occ;
  logic [CW:0]      limit;

  assign valid_out = ~empty;
  assign deq       = valid_out & id_ready & ~redirect;
  assign enq       = infl & ~redirect;

  // Issue while queued + in-flight - leaving stays below QDEPTH, written as
  // occ < QDEPTH + deq to avoid an unsigned subtraction. A redirect discards
  // everything, so the effective occupancy is zero and the request always goes.
  assign occ      = {1'b0, count} + (CW+1)'(infl);
  assign limit    = (CW+1)'(QDEPTH) + (CW+1)'(deq);
  assign imem_req = ~rst & (redirect | (occ < limit));

  assign imem_addr = redirect ? redirect_pc : fpc;
  assign next_pc   = imem_addr + ISIZE'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      infl     <= 1'b0;
      infl_npc <= '0;
    end else if (imem_req) begin
      fpc      <= next_pc;
      infl     <= 1'b1;
      infl_npc <= next_pc;
    end else begin
      infl     <= 1'b0;
    end
  end

  inst_fifo #(
    .WIDTH (DSIZE + ISIZE),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (enq),
    .pop   (deq),
    .din   ({imem_rdata, infl_npc}),
    .head  ({inst_out, npc_out}),
    .count (count),
    .empty (empty)
  );

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam int          QDEPTH   = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        id_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        valid_out;
  logic [15:0] inst_out;
  logic [15:0] npc_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] npc;
  } entry_t;

  // expected entries, oldest first: queued ones followed by the in-flight one
  entry_t      sb[$];
  logic [15:0] fpc_m;
  logic        infl_m;

  always #5 clk = ~clk;

  if_id_stage #(
    .ISIZE    (16),
    .DSIZE    (16),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_out   (valid_out),
    .inst_out    (inst_out),
    .npc_out     (npc_out)
  );

  // memory holds word k at address k; junk on cycles without a request
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after posedge; evaluate the cycle on negedge and
  // advance the model to what the next posedge must produce.
  int          occ_m;
  logic        exp_valid;
  logic        deq_m;
  logic        exp_req;
  logic [15:0] exp_addr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req",   32'(imem_req),  32'd0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_addr",  32'(imem_addr), 32'(RESET_PC));
      chk("rst_inst",  32'(inst_out),  32'd0);
      chk("rst_npc",   32'(npc_out),   32'd0);
      sb.delete();
      fpc_m  = RESET_PC;
      infl_m = 1'b0;
    end else begin
      occ_m     = sb.size();
      exp_valid = (occ_m - int'(infl_m)) > 0;
      chk("valid", 32'(valid_out), 32'(exp_valid));
      if (exp_valid) begin
        chk("inst", 32'(inst_out), 32'(sb[0].inst));
        chk("npc",  32'(npc_out),  32'(sb[0].npc));
      end
      deq_m    = exp_valid & id_ready & ~redirect;
      exp_req  = redirect | ((occ_m - int'(deq_m)) < QDEPTH);
      exp_addr = redirect ? redirect_pc : fpc_m;
      chk("req",  32'(imem_req),  32'(exp_req));
      chk("addr", 32'(imem_addr), 32'(exp_addr));
      if (redirect) sb.delete();
      else if (deq_m) void'(sb.pop_front());
      if (exp_req) begin
        sb.push_back('{inst: exp_addr, npc: exp_addr + 16'd1});
        fpc_m  = exp_addr + 16'd1;
        infl_m = 1'b1;
      end else begin
        infl_m = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(2);
    rst = 1'b0;
    // streaming from reset, then a 5-cycle decode stall
    cycles(5);
    id_ready = 1'b0;
    cycles(5);
    id_ready = 1'b1;
    cycles(4);
    // fill the queue, then redirect to 0x0040 with id_ready high
    id_ready = 1'b0;
    cycles(3);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    cycles(1);
    redirect = 1'b0;
    cycles(6);
    // redirect while a word is in flight and decode is stalled
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    id_ready = 1'b0;
    cycles(1);
    redirect = 1'b0;
    cycles(3);
    id_ready = 1'b1;
    cycles(4);
    // PC wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    cycles(1);
    redirect = 1'b0;
    cycles(6);
    // random back-pressure and redirects
    for (int i = 0; i < 300; i++) begin
      id_ready    = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      cycles(1);
    end
    redirect = 1'b0;
    id_ready = 1'b0;
    cycles(4);
    // asynchronous reset mid-cycle with the queue full
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_req",   32'(imem_req),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    id_ready = 1'b1;
    cycles(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
